// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the next-PC sequencer
package pc_seq_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam int PC_STEP = 4;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_JMP  = 3'd2,
    SRC_TRAP = 3'd3,
    SRC_HOLD = 3'd4
  } src_t;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC source priority and misalignment check
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] TRAP_ADDR = ADDR_W'(8'hF0)
) (
  input  logic              rst,
  input  state_t            state,
  input  logic [ADDR_W-1:0] pc_current_address,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              md_busy,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc_target_addr,
  output logic              load,
  output src_t              src
);

  logic [ADDR_W-1:0] cand;
  logic              cand_misaligned;

  assign cand            = jump_valid ? jump_target : branch_target;
  assign cand_misaligned = (cand[1:0] != 2'b00);

  always_comb begin
    src = SRC_HOLD;
    if (rst) begin
      src = SRC_HOLD;
    end else if (state == ST_HALT) begin
      src = resume ? SRC_SEQ : SRC_HOLD;
    end else if (md_busy || halt_req) begin
      src = SRC_HOLD;
    end else if (jump_valid) begin
      src = cand_misaligned ? SRC_TRAP : SRC_JMP;
    end else if (branch_taken) begin
      src = cand_misaligned ? SRC_TRAP : SRC_BR;
    end else begin
      src = SRC_SEQ;
    end
  end

  always_comb begin
    pc_target_addr = pc_current_address;
    case (src)
      SRC_SEQ:  pc_target_addr = pc_current_address + ADDR_W'(PC_STEP);
      SRC_BR:   pc_target_addr = branch_target;
      SRC_JMP:  pc_target_addr = jump_target;
      SRC_TRAP: pc_target_addr = TRAP_ADDR;
      default:  pc_target_addr = rst ? '0 : pc_current_address;
    endcase
  end

  assign load = (src != SRC_HOLD);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC controller with trap capture, halt state and retire counter
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] TRAP_ADDR = ADDR_W'(8'hF0),
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_current_address,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              md_busy,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc_target_addr,
  output logic              load,
  output logic [ADDR_W-1:0] epc,
  output logic              trap,
  output logic              halted,
  output logic [CNT_W-1:0]  instret
);

  state_t state;
  src_t   src;

  pc_next_sel #(
    .ADDR_W    (ADDR_W),
    .TRAP_ADDR (TRAP_ADDR)
  ) u_sel (
    .rst                (rst),
    .state              (state),
    .pc_current_address (pc_current_address),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .jump_valid         (jump_valid),
    .jump_target        (jump_target),
    .md_busy            (md_busy),
    .halt_req           (halt_req),
    .resume             (resume),
    .pc_target_addr     (pc_target_addr),
    .load               (load),
    .src                (src)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      halted  <= 1'b0;
      epc     <= '0;
      trap    <= 1'b0;
      instret <= '0;
    end else begin
      trap <= (src == SRC_TRAP);
      if (src == SRC_TRAP) epc <= pc_current_address;
      // Trap redirects load the PC but do not retire the faulting instruction.
      if (load && (src != SRC_TRAP)) instret <= instret + 1'b1;
      case (state)
        ST_RUN: begin
          if (!md_busy && halt_req) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end
        end
        ST_HALT: begin
          if (resume) begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized bench against a behavioural next-PC model
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pc_current_address;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       jump_valid;
  logic [7:0] jump_target;
  logic       md_busy;
  logic       halt_req;
  logic       resume;
  logic [7:0] pc_target_addr;
  logic       load;
  logic [7:0] epc;
  logic       trap;
  logic       halted;
  logic [15:0] instret;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  int m_pc = 0;
  bit m_halt = 0;
  int m_epc = 0;
  bit m_trap = 0;
  int m_instret = 0;

  pc_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .pc_current_address (pc_current_address),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .jump_valid         (jump_valid),
    .jump_target        (jump_target),
    .md_busy            (md_busy),
    .halt_req           (halt_req),
    .resume             (resume),
    .pc_target_addr     (pc_target_addr),
    .load               (load),
    .epc                (epc),
    .trap               (trap),
    .halted             (halted),
    .instret            (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic cyc(input bit r, input bit bt, input int bta, input bit jv, input int jta,
                     input bit mb, input bit hr, input bit res, input int pc_ovr);
    int  pc;
    int  e_tgt;
    bit  e_load;
    bit  e_trap;
    bit  go_halt;
    int  cand;
    @(posedge clk);
    #1;
    pc = (pc_ovr >= 0) ? pc_ovr : m_pc;
    rst = r; branch_taken = bt; branch_target = 8'(bta); jump_valid = jv;
    jump_target = 8'(jta); md_busy = mb; halt_req = hr; resume = res;
    pc_current_address = 8'(pc);
    e_tgt = pc; e_load = 0; e_trap = 0; go_halt = 0;
    if (r) begin
      e_tgt = 0;
    end else if (m_halt) begin
      if (res) begin e_tgt = (pc + 4) % 256; e_load = 1; end
    end else if (mb) begin
      e_load = 0;
    end else if (hr) begin
      go_halt = 1;
    end else if (jv || bt) begin
      cand = jv ? jta : bta;
      e_load = 1;
      if (cand % 4 != 0) begin e_tgt = 8'hF0; e_trap = 1; end
      else e_tgt = cand;
    end else begin
      e_tgt = (pc + 4) % 256; e_load = 1;
    end
    @(negedge clk);
    chk("load", int'(load), int'(e_load));
    chk("target", int'(pc_target_addr), e_tgt);
    chk("trap", int'(trap), int'(m_trap));
    chk("epc", int'(epc), m_epc);
    chk("halted", int'(halted), int'(m_halt));
    chk("instret", int'(instret), m_instret);
    if (r) begin
      m_pc = 0; m_halt = 0; m_epc = 0; m_trap = 0; m_instret = 0;
    end else begin
      if (e_load) m_pc = e_tgt; else m_pc = pc;
      m_trap = e_trap;
      if (e_trap) m_epc = pc;
      if (e_load && !e_trap) m_instret = (m_instret + 1) % 65536;
      if (go_halt) m_halt = 1;
      else if (m_halt && res) m_halt = 0;
    end
  endtask

  initial begin
    int bta, jta;
    rst = 1'b1; branch_taken = 0; branch_target = 0; jump_valid = 0; jump_target = 0;
    md_busy = 0; halt_req = 0; resume = 0; pc_current_address = 0;

    // reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0, -1);
    chk("rst_load", int'(load), 0);
    chk("rst_target", int'(pc_target_addr), 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, -1);
    chk("rst_instret", int'(instret), 0);
    chk("rst_halted", int'(halted), 0);

    // free-running sequential fetch
    cyc(0, 0, 0, 0, 0, 0, 0, 0, -1); chk("seq1", int'(pc_target_addr), 'h04);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, -1); chk("seq2", int'(pc_target_addr), 'h08);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, -1); chk("seq3", int'(pc_target_addr), 'h0C);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, -1); chk("seq4", int'(pc_target_addr), 'h10);

    // jump beats branch
    cyc(0, 1, 'h40, 1, 'h80, 0, 0, 0, 'h20);
    chk("seq_instret", int'(instret), 4);
    chk("jmp_target", int'(pc_target_addr), 'h80);
    chk("jmp_load", int'(load), 1);

    // misaligned jump traps
    cyc(0, 0, 0, 1, 'h46, 0, 0, 0, 'h30);
    chk("trap_target", int'(pc_target_addr), 'hF0);
    // stall with pending halt; trap pulse visible on its first cycle
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 'h10);
    chk("trap_pulse", int'(trap), 1);
    chk("trap_epc", int'(epc), 'h30);
    chk("trap_instret", int'(instret), 5);
    chk("stall1_load", int'(load), 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 'h10);
    chk("trap_once", int'(trap), 0);
    chk("stall2_load", int'(load), 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 'h10);
    chk("stall3_load", int'(load), 0);
    chk("stall_halted", int'(halted), 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 'h10);
    chk("halt_load", int'(load), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 'h10);
    chk("halted_rise", int'(halted), 1);
    chk("resume_target", int'(pc_target_addr), 'h14);
    chk("resume_load", int'(load), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, -1);
    chk("halted_fall", int'(halted), 0);

    // PC wrap, then reset out of HALT
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 'hFC);
    chk("wrap_target", int'(pc_target_addr), 'h00);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, -1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, -1);
    chk("halt_before_rst", int'(halted), 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, -1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, -1);
    chk("rst_halt_clear", int'(halted), 0);
    chk("rst_instret_clear", int'(instret), 1 - 1);
    chk("rst_run_load", int'(load), 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bta = int'($urandom_range(0, 63)) * 4 + (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      jta = int'($urandom_range(0, 63)) * 4 + (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0, bta,
          $urandom_range(0, 3) == 0, jta, $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
          ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the RV32IM single-cycle core. Each cycle it chooses the next fetch address from sequential, branch, jump, trap, stall and halt conditions. It drives the `pc` register's `pc_target_addr` and `load` inputs. It also keeps the exception PC, a trap flag, a halted/debug state and a retired-instruction counter. The block sits between the decode/ALU/branch-compare logic and the `pc` register, and replaces the tie-high of `load`.

## Interface
- `ADDR_W`, 8, PC width in bits (byte address).
- `TRAP_ADDR`, 8'hF0, redirect target for misaligned control-transfer traps.
- `CNT_W`, 16, width of the retired-instruction counter.

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `pc_current_address`  in  ADDR_W  current PC from `pc` register.
- `branch_taken`  in  1  conditional branch resolved taken this cycle.
- `branch_target`  in  ADDR_W  branch destination.
- `jump_valid`  in  1  JAL/JALR this cycle.
- `jump_target`  in  ADDR_W  jump destination (JALR LSB already cleared).
- `md_busy`  in  1  multi-cycle MUL/DIV unit busy; hold PC.
- `halt_req`  in  1  EBREAK/ECALL decoded this cycle.
- `resume`  in  1  leave HALT state.
- `pc_target_addr`  out  ADDR_W  next PC to the `pc` register.
- `load`  out  1  `pc` register write enable.
- `epc`  out  ADDR_W  PC of the last trapping instruction.
- `trap`  out  1  one-cycle pulse, the cycle after a trap redirect.
- `halted`  out  1  high while in HALT.
- `instret`  out  CNT_W  retired-instruction count.

## Operation
- Two-state FSM: RUN, HALT. Reset state is RUN.
- `pc_target_addr` and `load` are combinational from the state and the inputs. Priority in RUN, highest first:
  1. `md_busy` → `load`=0. All other inputs are ignored this cycle.
  2. `halt_req` → `load`=0. Next state is HALT. Branch/jump inputs are ignored.
  3. `jump_valid`, else `branch_taken` → the candidate is `jump_target` or `branch_target`.
     - If candidate[1:0] != 0: trap. Target = `TRAP_ADDR`, `load`=1, `epc` <= `pc_current_address`, `trap` is set for the next cycle.
     - Otherwise target = candidate, `load`=1.
  4. Default → target = `pc_current_address` + 4, modulo 2^ADDR_W (0xFC → 0x00), `load`=1.
- HALT:
  - `load`=0 and `halted`=1.
  - `resume`=1 → target = `pc_current_address` + 4, `load`=1, next state is RUN (steps past the EBREAK).
  - `resume` is ignored in RUN. `halt_req` is ignored in HALT.
- `instret` increments by 1 in every cycle with `load`=1 and no trap. It wraps at 2^CNT_W.
- When `load`=0, `pc_target_addr` = `pc_current_address`.

## Timing
- Redirect decisions are zero-latency: the `pc` register takes the new value at the next edge.
- `trap` and `epc` are registered. They update at the edge that loads `TRAP_ADDR`. `trap` is high for exactly one cycle. `epc` holds until the next trap.
- `halted` is registered. It rises the cycle after `halt_req` and falls the cycle after `resume`.
- Reset values: state RUN, `epc`=0, `trap`=0, `halted`=0, `instret`=0.
- While `rst`=1: `load`=0 and `pc_target_addr`=0. The `pc` register resets itself.
- Reset asserted in HALT or during a stall → RUN on the next edge. No pending trap survives reset.
- `halt_req` together with `md_busy`: the stall wins. The halt is taken in the first cycle `md_busy`=0, if `halt_req` is still asserted (decode holds it).
- `jump_valid` together with `branch_taken`: the jump wins.

## Structure
- Shared package `pc_seq_pkg`:
  - state enum (RUN, HALT);
  - `PC_STEP`=4;
  - next-PC source encoding (SEQ, BR, JMP, TRAP, HOLD).
- One natural sub-module, `pc_next_sel`: combinational priority/source select and misalignment check. The FSM, `epc`/`trap` registers and `instret` stay in `pc_sequencer`.

## Test plan
- Reset, then 4 free-running cycles with PC from the `pc` register → targets 0x04, 0x08, 0x0C, 0x10; `instret`=4.
- PC=0x20, `branch_taken`=1, `branch_target`=0x40, same cycle `jump_valid`=1, `jump_target`=0x80 → target 0x80, `load`=1, no trap.
- PC=0x30, `jump_target`=0x46 → target 0xF0. Next cycle: `trap`=1, `epc`=0x30, `instret` unchanged.
- PC=0x10, `md_busy` for 3 cycles with `halt_req`=1 throughout → `load`=0 for 4 cycles. `halted` rises after the stall ends. `resume` → target 0x14.
- PC=0xFC, sequential → target 0x00. Assert `rst` while in HALT → `halted`=0, `instret`=0, state RUN after one edge.
